pe3x3_seq: RTL
==============

# pe3x3_seq

Sequencer and accumulator for the `pe3x3` row-MAC datapath. It walks the three kernel rows across `cfg_cin` input channels, issues one read per cycle to the feature-map and weight buffers, and accumulates the PE's `OUTPUT_NUM` signed partial sums into `DW_ADD`-bit lanes. It then presents the finished lane vector on a valid/ready output. It sits between the on-chip buffers and the output/requantisation stage of the convolution engine.

## Interface
- `OUTPUT_NUM`, 9, number of PE result lanes.
- `DW_ADD`, 32, accumulator and lane width, in bits.
- `AW`, 10, buffer address width.
- `CIN_W`, 8, width of the channel-count field.
- `clk`  in  1  clock. One clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle start request. Ignored while `busy`.
- `cfg_cin`  in  CIN_W  input-channel count. Sampled when `start` is accepted.
- `cfg_fm_base`  in  AW  feature-map base address. Sampled when `start` is accepted.
- `cfg_wt_base`  in  AW  weight base address. Sampled when `start` is accepted.
- `busy`  out  1  high while a job is active.
- `done`  out  1  one-cycle pulse, the cycle after the output handshake.
- `fm_rd_en`  out  1  feature-map buffer read strobe.
- `fm_rd_addr`  out  AW  feature-map read address.
- `wt_rd_en`  out  1  weight buffer read strobe.
- `wt_rd_addr`  out  AW  weight read address.
- `pe_psum`  in  OUTPUT_NUM*DW_ADD  signed PE results. Valid one cycle after a read strobe.
- `out_valid`  out  1  accumulated result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  OUTPUT_NUM*DW_ADD  accumulated lanes. Lane 0 occupies the LSBs.

## Operation
- States: IDLE, RUN, FLUSH, OUT.
- IDLE → RUN on `start` when `cfg_cin` ≠ 0.
  - On the accepting edge: latch all config inputs, clear all accumulators, zero `ky` and `ci`.
- IDLE → OUT on `start` when `cfg_cin` = 0. All lanes are presented as zero.
- RUN issues one read per cycle.
  - `fm_rd_en` = `wt_rd_en` = 1.
  - `fm_rd_addr` = `fm_base` + 3·`ci` + `ky`.
  - `wt_rd_addr` = `wt_base` + 3·`ci` + `ky`.
  - `ky` is the inner counter (0..2). `ci` is the outer counter (0..`cin`−1).
  - After the read with `ci` = `cin`−1 and `ky` = 2, go to FLUSH.
- Accumulate strobe `acc_en` is the read strobe delayed by one register.
  - When `acc_en` = 1, each lane computes `acc[k]` += `pe_psum[k]`, using a signed `DW_ADD`-bit add.
- FLUSH takes one cycle, for the final accumulate, then goes to OUT.
- OUT holds `out_valid` = 1 and `out_data` stable until `out_valid` && `out_ready`. Then go to IDLE and pulse `done` on the next cycle.
- Addresses wrap modulo 2^AW.
- `start` while `busy` is ignored and does not alter config or accumulators.
- Reset asserted mid-job aborts the job immediately. No `done` is produced.
- Reset values: state = IDLE; `busy`, `done`, `fm_rd_en`, `wt_rd_en`, `out_valid` = 0; both addresses = 0; `out_data` = 0.

## Timing
- `start` accepted at edge 0.
- Reads are issued on cycles 1..3·cin.
- Accumulates occur on cycles 2..3·cin+1. The last one falls in FLUSH.
- `out_valid` rises at cycle 3·cin+2.
- Latency from `start` to `out_valid` is 3·cin+2 cycles, or 1 cycle when cin = 0.
- `busy` is high from cycle 1 through the handshake cycle.
- Back-to-back jobs: a new `start` is accepted in the same cycle `done` is high.

## Configuration
- `PE3X3_SEQ_SAT_EN` defined: each accumulate saturates to the signed `DW_ADD` range.
  - Upper clamp: 2^(DW_ADD−1)−1. Lower clamp: −2^(DW_ADD−1).
- Not defined: accumulation wraps modulo 2^DW_ADD.

## Structure
- Shared package `pe_pkg` holds:
  - `DW_IN`, `DW_ADD`, `OUTPUT_NUM` defaults.
  - Kernel height constant `KH` = 3.
  - State enum `pe_seq_state_t`.
- One sub-module, `pe_acc_bank`: `OUTPUT_NUM` lanes with clear, enable and the optional saturating adder.

## Test plan
- Reset values: hold `rst_n` low, then release. All outputs read 0 and state is IDLE.
- Address sequence: cin = 2, `fm_base` = 0x10, `wt_base` = 0x20, `pe_psum` lanes all = 1.
  - Addresses run 0x10..0x15 and 0x20..0x25 over exactly 6 read cycles.
  - `out_valid` at cycle 8; every lane = 6.
- Backpressure: hold `out_ready` low for 5 cycles after `out_valid`. Data stays stable; `done` pulses one cycle after `out_ready` rises.
- Zero channels: cin = 0. No reads issued; `out_valid` at cycle 1 with all lanes 0.
- Overflow: cin = 1, lane 0 `pe_psum` = 0x7FFFFFFF on all 3 reads.
  - With `PE3X3_SEQ_SAT_EN`: lane 0 = 0x7FFFFFFF.
  - Without: lane 0 = 0x7FFFFFFD.
- Abort and ignored start: pulse `start` while `busy`, and it is ignored. Drop `rst_n` mid-RUN. All outputs return to 0 and no `done` is produced.

Source files
------------

// File: rtl/pe_pkg.sv
// ----------------------------------------------------------------------------
// pe_pkg
// Shared constants and types for the pe3x3 convolution datapath.
//   DW_IN, DW_ADD, OUTPUT_NUM : default datapath widths / lane count
//   AW, CIN_W                 : default buffer address / channel-count widths
//   KH                        : kernel height (rows walked per input channel)
//   pe_seq_state_t            : sequencer state encoding
// ----------------------------------------------------------------------------
package pe_pkg;

  localparam int DW_IN      = 8;
  localparam int DW_ADD     = 32;
  localparam int OUTPUT_NUM = 9;
  localparam int AW         = 10;
  localparam int CIN_W      = 8;
  localparam int KH         = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } pe_seq_state_t;

endpackage

// File: rtl/pe3x3_seq_if.sv
// ----------------------------------------------------------------------------
// pe3x3_seq_if
// Buffer-read and result-stream bundle of the pe3x3 sequencer.
//   fm_rd_en / fm_rd_addr : feature-map buffer read strobe and address
//   wt_rd_en / wt_rd_addr : weight buffer read strobe and address
//   pe_psum               : PE lane results, valid one cycle after a read
//   out_valid / out_ready : result handshake
//   out_data              : accumulated lanes, lane 0 in the LSBs
// Modports: master = sequencer side, slave = buffers / downstream side.
// ----------------------------------------------------------------------------
interface pe3x3_seq_if #(
  parameter int OUTPUT_NUM = pe_pkg::OUTPUT_NUM,
  parameter int DW_ADD     = pe_pkg::DW_ADD,
  parameter int AW         = pe_pkg::AW
);

  logic                         fm_rd_en;
  logic [AW-1:0]                fm_rd_addr;
  logic                         wt_rd_en;
  logic [AW-1:0]                wt_rd_addr;
  logic [OUTPUT_NUM*DW_ADD-1:0] pe_psum;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUTPUT_NUM*DW_ADD-1:0] out_data;

  modport master (
    output fm_rd_en, fm_rd_addr, wt_rd_en, wt_rd_addr, out_valid, out_data,
    input  pe_psum, out_ready
  );

  modport slave (
    input  fm_rd_en, fm_rd_addr, wt_rd_en, wt_rd_addr, out_valid, out_data,
    output pe_psum, out_ready
  );

endinterface

// File: rtl/pe_acc_bank.sv
// ----------------------------------------------------------------------------
// pe_acc_bank
// LANES independent signed DW-bit accumulators.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero every lane (has priority over en)
//   en         : add psum lane k into accumulator lane k
//   psum       : packed lane inputs, lane 0 in the LSBs
//   acc        : packed accumulator contents, lane 0 in the LSBs
// Build option: PE3X3_SEQ_SAT_EN defined -> each add clamps to the signed
// DW range; otherwise the add wraps modulo 2^DW.
// ----------------------------------------------------------------------------
module pe_acc_bank #(
  parameter int LANES = pe_pkg::OUTPUT_NUM,
  parameter int DW    = pe_pkg::DW_ADD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic [LANES*DW-1:0] psum,
  output logic [LANES*DW-1:0] acc
);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DW-1:0] acc_reg;
      logic signed [DW-1:0] acc_next;
      logic signed [DW-1:0] addend;

      assign addend = psum[gi*DW +: DW];

`ifdef PE3X3_SEQ_SAT_EN
      // One extra bit catches overflow: the top two bits disagree exactly
      // when the true sum left the DW-bit signed range.
      logic signed [DW:0] wide_sum;
      assign wide_sum = {acc_reg[DW-1], acc_reg} + {addend[DW-1], addend};

      always_comb begin
        acc_next = wide_sum[DW-1:0];
        if (wide_sum[DW] != wide_sum[DW-1]) begin
          acc_next = wide_sum[DW] ? {1'b1, {(DW-1){1'b0}}}
                                  : {1'b0, {(DW-1){1'b1}}};
        end
      end
`else
      assign acc_next = acc_reg + addend;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg <= '0;
        end else if (clr) begin
          acc_reg <= '0;
        end else if (en) begin
          acc_reg <= acc_next;
        end
      end

      assign acc[gi*DW +: DW] = acc_reg;
    end
  endgenerate

endmodule

// File: rtl/pe3x3_seq.sv
// ----------------------------------------------------------------------------
// pe3x3_seq
// Walks the KH kernel rows over cfg_cin input channels, issuing one buffer
// read per cycle, accumulates the PE lane results and presents them on a
// valid/ready output.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle job request (ignored while busy)
//   cfg_cin      : input-channel count, latched on start
//   cfg_fm_base  : feature-map base address, latched on start
//   cfg_wt_base  : weight base address, latched on start
//   busy         : job active (RUN, FLUSH or OUT)
//   done         : one-cycle pulse after the output handshake
//   bus          : pe3x3_seq_if master (buffer reads, pe_psum, result stream)
// Build option: PE3X3_SEQ_SAT_EN selects saturating accumulation.
// ----------------------------------------------------------------------------
module pe3x3_seq #(
  parameter int OUTPUT_NUM = pe_pkg::OUTPUT_NUM,
  parameter int DW_ADD     = pe_pkg::DW_ADD,
  parameter int AW         = pe_pkg::AW,
  parameter int CIN_W      = pe_pkg::CIN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CIN_W-1:0] cfg_cin,
  input  logic [AW-1:0]    cfg_fm_base,
  input  logic [AW-1:0]    cfg_wt_base,
  output logic             busy,
  output logic             done,
  pe3x3_seq_if.master      bus
);

  import pe_pkg::*;

  pe_seq_state_t    state_reg, state_next;
  logic [1:0]       ky_reg, ky_next;
  logic [CIN_W-1:0] ci_reg, ci_next;
  logic [CIN_W-1:0] cin_reg;
  logic [AW-1:0]    fm_base_reg, wt_base_reg;
  logic             acc_en_reg;
  logic             done_reg;
  logic             load;
  logic             rd_en;
  logic [AW-1:0]    rd_off;

  always_comb begin
    state_next = state_reg;
    ky_next    = ky_reg;
    ci_next    = ci_reg;
    load       = 1'b0;
    rd_en      = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          ky_next    = '0;
          ci_next    = '0;
          state_next = (cfg_cin == '0) ? ST_OUT : ST_RUN;
        end
      end
      ST_RUN: begin
        rd_en = 1'b1;
        if (ky_reg == 2'(KH - 1)) begin
          ky_next = '0;
          if (ci_reg == cin_reg - CIN_W'(1)) begin
            state_next = ST_FLUSH;
          end else begin
            ci_next = ci_reg + CIN_W'(1);
          end
        end else begin
          ky_next = ky_reg + 2'd1;
        end
      end
      // Lets the accumulate for the last read land before results show.
      ST_FLUSH: state_next = ST_OUT;
      ST_OUT: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ky_reg      <= '0;
      ci_reg      <= '0;
      cin_reg     <= '0;
      fm_base_reg <= '0;
      wt_base_reg <= '0;
      acc_en_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ky_reg     <= ky_next;
      ci_reg     <= ci_next;
      // PE results arrive one cycle after their read strobe.
      acc_en_reg <= rd_en;
      done_reg   <= (state_reg == ST_OUT) && bus.out_ready;
      if (load) begin
        cin_reg     <= cfg_cin;
        fm_base_reg <= cfg_fm_base;
        wt_base_reg <= cfg_wt_base;
      end
    end
  end

  // Row offset KH*ci + ky; truncation to AW bits gives the modulo wrap.
  assign rd_off = AW'(32'(ci_reg) * KH + 32'(ky_reg));

  assign bus.fm_rd_en   = rd_en;
  assign bus.wt_rd_en   = rd_en;
  assign bus.fm_rd_addr = rd_en ? fm_base_reg + rd_off : '0;
  assign bus.wt_rd_addr = rd_en ? wt_base_reg + rd_off : '0;
  assign bus.out_valid  = (state_reg == ST_OUT);
  assign busy           = (state_reg != ST_IDLE);
  assign done           = done_reg;

  pe_acc_bank #(
    .LANES (OUTPUT_NUM),
    .DW    (DW_ADD)
  ) u_acc_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .en    (acc_en_reg),
    .psum  (bus.pe_psum),
    .acc   (bus.out_data)
  );

endmodule
